// File: rtl/shift_sensor_scanner.sv
// Scanner for a daisy-chained parallel-in/serial-out sensor chain: drives the shift clock and
// load strobe, shifts in NUM_BITS per scan, debounces across scans and publishes a stable word.
module shift_sensor_scanner #(
    parameter int                  NUM_BITS   = 32,
    parameter int                  CLK_DIV    = 100,
    parameter int                  SCAN_GAP   = 256,
    parameter int                  DEBOUNCE   = 3,
    parameter int                  INVERT     = 1,
    parameter logic [NUM_BITS-1:0] FORCE_MASK = NUM_BITS'(32'h0800_0000),
    parameter logic [NUM_BITS-1:0] FORCE_VAL  = NUM_BITS'(32'h0800_0000)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic                o_sr_clk,
    output logic                o_sr_load_n,
    input  logic                i_sr_data,
    input  logic                i_scan_req,
    output logic [NUM_BITS-1:0] o_data_out,
    output logic                o_data_valid,
    output logic                o_change_pulse,
    output logic                o_scan_busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int BIT_W = $clog2(NUM_BITS);
    localparam int STB_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [STB_W-1:0]    r_stable_cnt;
    logic                r_sr_clk;
    logic                r_sr_load_n;
    logic                r_req_pend;
    logic [NUM_BITS-1:0] r_shreg;
    logic [NUM_BITS-1:0] r_prev_cand;
    logic [NUM_BITS-1:0] r_data_out;
    logic                r_data_valid;
    logic                r_change_pulse;
    logic                r_scan_busy;

    logic                w_tick;
    logic                w_rise;
    logic [NUM_BITS-1:0] w_pol;
    logic [NUM_BITS-1:0] w_cand;
    logic [STB_W-1:0]    w_stable_next;
    logic                w_publish;

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_rise = w_tick & ~r_sr_clk;

    assign w_pol  = (INVERT != 0) ? ~r_shreg : r_shreg;
    assign w_cand = (w_pol & ~FORCE_MASK) | (FORCE_VAL & FORCE_MASK);

    // Run length of identical candidates; saturates so it never wraps back below DEBOUNCE.
    assign w_stable_next = (w_cand != r_prev_cand)  ? STB_W'(1) :
                           (r_stable_cnt == STB_MAX) ? STB_MAX   :
                                                       r_stable_cnt + STB_W'(1);
    assign w_publish = (w_stable_next == STB_MAX) && (!r_data_valid || (w_cand != r_data_out));

    // Free-running divider: sr_clk is never gated, stretched or restarted by a scan request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_sr_clk  <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sr_clk  <= ~r_sr_clk;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_gap_cnt      <= '0;
            r_bit_cnt      <= '0;
            r_stable_cnt   <= '0;
            r_sr_load_n    <= 1'b1;
            r_req_pend     <= 1'b0;
            // NOTE: shreg and prev_cand are reset too, so an aborted scan leaves no partial word or history behind.
            r_shreg        <= '0;
            r_prev_cand    <= '0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_change_pulse <= 1'b0;
            r_scan_busy    <= 1'b0;
        end else begin
            r_change_pulse <= 1'b0;
            if (i_scan_req) begin
                r_req_pend <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        if ((r_gap_cnt == GAP_LAST) || r_req_pend) begin
                            r_state     <= S_LOAD;
                            r_sr_load_n <= 1'b0;
                            r_gap_cnt   <= '0;
                            r_scan_busy <= 1'b1;
                            // A request arriving in this very cycle must survive the clear.
                            r_req_pend  <= i_scan_req;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        end
                    end
                end

                S_LOAD: begin
                    if (w_rise) begin
                        r_sr_load_n <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (w_rise) begin
                        r_shreg[r_bit_cnt] <= i_sr_data;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= S_COMMIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    r_prev_cand  <= w_cand;
                    r_stable_cnt <= w_stable_next;
                    if (w_publish) begin
                        r_data_out     <= w_cand;
                        r_data_valid   <= 1'b1;
                        r_change_pulse <= r_data_valid;
                    end
                    r_state     <= S_IDLE;
                    r_scan_busy <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sr_clk       = r_sr_clk;
    assign o_sr_load_n    = r_sr_load_n;
    assign o_data_out     = r_data_out;
    assign o_data_valid   = r_data_valid;
    assign o_change_pulse = r_change_pulse;
    assign o_scan_busy    = r_scan_busy;

endmodule

// File: tb/tb_shift_sensor_scanner.sv
// Bench for shift_sensor_scanner: two instances (debounced/inverted/forced and plain), each fed by a
// 74HC165-style chain model, with a scan-history reference model deciding what gets published.
`timescale 1ns/1ps
module tb_shift_sensor_scanner;

    localparam int NB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic       rst0, rst1, req0, req1;
    logic       sd0 = 1'b0, sd1 = 1'b0;
    logic       sclk0, ld0, valid0, pulse0, busy0;
    logic       sclk1, ld1, valid1, pulse1, busy1;
    logic [7:0] dout0, dout1;

    shift_sensor_scanner #(
        .NUM_BITS(NB), .CLK_DIV(2), .SCAN_GAP(4), .DEBOUNCE(2), .INVERT(1),
        .FORCE_MASK(8'h08), .FORCE_VAL(8'h08)
    ) u_dut0 (
        .i_clk(clk), .i_reset(rst0), .o_sr_clk(sclk0), .o_sr_load_n(ld0), .i_sr_data(sd0),
        .i_scan_req(req0), .o_data_out(dout0), .o_data_valid(valid0),
        .o_change_pulse(pulse0), .o_scan_busy(busy0)
    );

    shift_sensor_scanner #(
        .NUM_BITS(NB), .CLK_DIV(2), .SCAN_GAP(4), .DEBOUNCE(1), .INVERT(0),
        .FORCE_MASK(8'h00), .FORCE_VAL(8'h00)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst1), .o_sr_clk(sclk1), .o_sr_load_n(ld1), .i_sr_data(sd1),
        .i_scan_req(req1), .o_data_out(dout1), .o_data_valid(valid1),
        .o_change_pulse(pulse1), .o_scan_busy(busy1)
    );

    // Chain models: parallel load while load_n is low; a rising sr_clk shifts only if load_n was high before it.
    logic [7:0] raw_w [2];
    logic [7:0] chain0 = 8'h00, chain1 = 8'h00;
    int         idx0 = 0, idx1 = 0;
    logic       p_sclk0 = 1'b0, p_ld0 = 1'b1, p_sclk1 = 1'b0, p_ld1 = 1'b1;

    always @(negedge clk) begin
        if (ld0 == 1'b0) begin
            chain0 = raw_w[0];
            idx0   = 0;
        end else if (sclk0 && !p_sclk0 && p_ld0) begin
            idx0 = idx0 + 1;
        end
        p_sclk0 = sclk0;
        p_ld0   = ld0;
        sd0     = (idx0 < NB) ? chain0[idx0] : 1'b0;
    end

    always @(negedge clk) begin
        if (ld1 == 1'b0) begin
            chain1 = raw_w[1];
            idx1   = 0;
        end else if (sclk1 && !p_sclk1 && p_ld1) begin
            idx1 = idx1 + 1;
        end
        p_sclk1 = sclk1;
        p_ld1   = ld1;
        sd1     = (idx1 < NB) ? chain1[idx1] : 1'b0;
    end

    // Reference model: a word is published once the last DEBOUNCE scans since reset agree and differ from data_out.
    logic [7:0] hist0[$];
    logic [7:0] hist1[$];
    logic [7:0] m_dout  [2];
    logic       m_valid [2];
    logic       m_pulse [2];

    function automatic logic sclk_of(input int d);  return (d == 0) ? sclk0  : sclk1;  endfunction
    function automatic logic ld_of(input int d);    return (d == 0) ? ld0    : ld1;    endfunction
    function automatic logic busy_of(input int d);  return (d == 0) ? busy0  : busy1;  endfunction
    function automatic logic valid_of(input int d); return (d == 0) ? valid0 : valid1; endfunction
    function automatic logic pulse_of(input int d); return (d == 0) ? pulse0 : pulse1; endfunction
    function automatic logic [7:0] dout_of(input int d); return (d == 0) ? dout0 : dout1; endfunction

    function automatic void model_reset(input int d);
        if (d == 0) hist0.delete(); else hist1.delete();
        m_dout[d]  = 8'h00;
        m_valid[d] = 1'b0;
        m_pulse[d] = 1'b0;
    endfunction

    function automatic void model_commit(input int d, input logic [7:0] raw);
        logic [7:0] c;
        logic [7:0] h[$];
        int         need;
        bit         stable;
        c    = (d == 0) ? ~raw : raw;
        c    = (d == 0) ? ((c & ~8'h08) | 8'h08) : c;
        need = (d == 0) ? 2 : 1;
        if (d == 0) begin
            hist0.push_back(c);
            h = hist0;
        end else begin
            hist1.push_back(c);
            h = hist1;
        end
        stable = (h.size() >= need);
        for (int i = 0; i < need; i++) begin
            if (h.size() > i && h[h.size() - 1 - i] !== c) stable = 1'b0;
        end
        m_pulse[d] = 1'b0;
        if (stable && (!m_valid[d] || c !== m_dout[d])) begin
            m_pulse[d] = m_valid[d];
            m_dout[d]  = c;
            m_valid[d] = 1'b1;
        end
    endfunction

    task automatic wait_rise(input int d, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = sclk_of(d);
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (sclk_of(d) && !prev) ok = 1'b1;
            prev = sclk_of(d);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL rise_timeout dut%0d: got no sr_clk rise, required one within 16 cycles", d);
        end
    endtask

    task automatic wait_busy_fall(input int d);
        bit seen, done;
        seen = busy_of(d);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (busy_of(d)) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL commit_timeout dut%0d: got no end of scan, required one within 400 cycles", d);
        end
    endtask

    task automatic finish_scan(input int d, input logic [7:0] raw, input string name);
        wait_busy_fall(d);
        model_commit(d, raw);
        n_checks++;
        if ({valid_of(d), pulse_of(d), dout_of(d)} !== {m_valid[d], m_pulse[d], m_dout[d]}) begin
            n_errors++;
            $display("FAIL %s dut%0d raw=%02h: got valid=%0b pulse=%0b data=%02h, required valid=%0b pulse=%0b data=%02h",
                     name, d, raw, valid_of(d), pulse_of(d), dout_of(d), m_valid[d], m_pulse[d], m_dout[d]);
        end
        @(negedge clk);
        n_checks++;
        if (pulse_of(d) !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_pulse_width dut%0d: got change_pulse=%0b one cycle later, required 0", name, d, pulse_of(d));
        end
    endtask

    task automatic scan(input int d, input logic [7:0] raw, input string name);
        raw_w[d] = raw;
        finish_scan(d, raw, name);
    endtask

    task automatic check_reset_values(input int d, input string name);
        n_checks++;
        if ({sclk_of(d), ld_of(d), valid_of(d), pulse_of(d), busy_of(d), dout_of(d)} !== {5'b01000, 8'h00}) begin
            n_errors++;
            $display("FAIL %s dut%0d: got sr_clk=%0b load_n=%0b valid=%0b pulse=%0b busy=%0b data=%02h, required 0 1 0 0 0 00",
                     name, d, sclk_of(d), ld_of(d), valid_of(d), pulse_of(d), busy_of(d), dout_of(d));
        end
    endtask

    task automatic test_reset();
        bit ok, done;
        int t1, low;
        repeat (4) @(negedge clk);
        check_reset_values(0, "reset_hold");
        check_reset_values(1, "reset_hold");
        rst0 = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            wait_rise(0, ok);
            if (r == 1) t1 = cyc;
            if (r == 2) begin
                n_checks++;
                if (cyc - t1 != 4) begin
                    n_errors++;
                    $display("FAIL sr_clk_period: got %0d clk, required 4", cyc - t1);
                end
            end
            n_checks++;
            if (ld0 !== ((r == 4) ? 1'b0 : 1'b1)) begin
                n_errors++;
                $display("FAIL first_load rise %0d: got load_n=%0b, required %0b", r, ld0, (r == 4) ? 1'b0 : 1'b1);
            end
        end
        low  = 1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ld0 === 1'b0) low++;
            else done = 1'b1;
        end
        n_checks++;
        if (low != 4) begin
            n_errors++;
            $display("FAIL load_width: got load_n low for %0d clk, required 4", low);
        end
    endtask

    task automatic test_first_publish();
        finish_scan(0, 8'hF0, "first_scan");
        scan(0, 8'hF0, "second_scan");
        n_checks++;
        if (dout0 !== 8'h0F) begin
            n_errors++;
            $display("FAIL first_publish_word: got %02h, required 0f", dout0);
        end
    endtask

    task automatic test_change();
        scan(0, 8'h3C, "change_a");
        scan(0, 8'h3C, "change_b");
        n_checks++;
        if (dout0 !== 8'hCB) begin
            n_errors++;
            $display("FAIL change_word: got %02h, required cb", dout0);
        end
        scan(0, 8'hF0, "back_a");
        scan(0, 8'hF0, "back_b");
        scan(0, 8'h3C, "glitch");
        scan(0, 8'hF0, "after_glitch");
        n_checks++;
        if (dout0 !== 8'h0F) begin
            n_errors++;
            $display("FAIL glitch_word: got %02h, required 0f", dout0);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [3];
        logic [7:0] w;
        for (int i = 0; i < 3; i++) pool[i] = 8'($urandom);
        for (int g = 0; g < 8; g++) begin
            w = pool[$urandom_range(0, 2)];
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) scan(0, w, "random");
        end
    endtask

    task automatic test_scan_req();
        bit ok;
        logic [7:0] y, z;
        y = 8'($urandom);
        z = 8'($urandom);
        raw_w[0] = y;
        wait_rise(0, ok);
        n_checks++;
        if (ld0 !== 1'b1) begin
            n_errors++;
            $display("FAIL req_idle_pre: got load_n=%0b at gap_cnt 0->1, required 1", ld0);
        end
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        wait_rise(0, ok);
        n_checks++;
        if (ld0 !== 1'b0) begin
            n_errors++;
            $display("FAIL req_idle_load: got load_n=%0b on next rise, required 0", ld0);
        end
        wait_rise(0, ok);
        wait_rise(0, ok);
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        finish_scan(0, y, "req_idle_scan");
        raw_w[0] = z;
        wait_rise(0, ok);
        n_checks++;
        if (ld0 !== 1'b0) begin
            n_errors++;
            $display("FAIL req_shift_load: got load_n=%0b on first rise after commit, required 0", ld0);
        end
        finish_scan(0, z, "req_shift_scan");
    endtask

    task automatic test_reset_mid_scan();
        bit ok, found;
        logic [7:0] x;
        x = 8'($urandom);
        scan(0, x, "pre_reset_a");
        scan(0, x, "pre_reset_b");
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            wait_rise(0, ok);
            if (ld0 === 1'b0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL mid_reset_load: got no load within 8 rises, required one");
        end
        wait_rise(0, ok);
        for (int b = 0; b < 5; b++) wait_rise(0, ok);
        rst0 = 1'b1;
        @(negedge clk);
        check_reset_values(0, "mid_scan_reset");
        rst0 = 1'b0;
        model_reset(0);
        scan(0, x, "post_reset_a");
        scan(0, x, "post_reset_b");
    endtask

    task automatic test_nodebounce();
        logic [7:0] a, b, c;
        logic [7:0] seq [$];
        a = 8'($urandom);
        b = a ^ 8'h5A;
        c = ~a;
        seq = '{a, a, b, b, b, c, a};
        for (int i = 0; i < 6; i++) seq.push_back(($urandom_range(0, 1) == 0) ? b : 8'($urandom));
        raw_w[1] = seq[0];
        @(negedge clk);
        rst1 = 1'b0;
        foreach (seq[i]) scan(1, seq[i], "nodebounce");
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        raw_w[0] = 8'hF0;
        raw_w[1] = 8'h00;
        model_reset(0);
        model_reset(1);
        test_reset();
        test_first_publish();
        test_change();
        test_random();
        test_scan_req();
        test_reset_mid_scan();
        test_nodebounce();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
